// File: rtl/flop_pipe_pkg.sv
// ============================================================================
// Module : flop_pipe_pkg
// Brief  : Shared defaults and legal parameter ranges for the flop_pipe_dp pipe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flop_pipe_pkg;

  localparam int FLOP_PIPE_WIDTH_DEF = 8;
  localparam int FLOP_PIPE_DEPTH_DEF = 2;

  localparam int FLOP_PIPE_WIDTH_MIN = 1;
  localparam int FLOP_PIPE_WIDTH_MAX = 64;
  localparam int FLOP_PIPE_DEPTH_MIN = 1;
  localparam int FLOP_PIPE_DEPTH_MAX = 16;

  function automatic bit flop_pipe_params_ok(input int width, input int depth);
    return (width >= FLOP_PIPE_WIDTH_MIN) && (width <= FLOP_PIPE_WIDTH_MAX) &&
           (depth >= FLOP_PIPE_DEPTH_MIN) && (depth <= FLOP_PIPE_DEPTH_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flop_pipe_stage.sv
// ============================================================================
// Module : flop_pipe_stage
// Brief  : One pipe stage: data register, valid bit, load mux and, when
//          FLOP_PIPE_SCAN_EN is defined, a scan-shift mux on the data bits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_pipe_stage
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = FLOP_PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
`ifdef FLOP_PIPE_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
`endif
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  // Data only captures real words so an emptied pipe keeps its last output.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
`ifdef FLOP_PIPE_SCAN_EN
    if (scan_en) begin
      valid_d   = valid_q;
      data_d    = data_q << 1;
      data_d[0] = scan_in;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flop_pipe_dp.sv
// ============================================================================
// Module : flop_pipe_dp
// Brief  : DEPTH-stage valid/ready register pipe with bubble collapse, flush
//          and optional scan chain (enabled by macro FLOP_PIPE_SCAN_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_pipe_dp
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = FLOP_PIPE_WIDTH_DEF,
  parameter int DEPTH = FLOP_PIPE_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
`ifdef FLOP_PIPE_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (!flop_pipe_params_ok(WIDTH, DEPTH)) begin : g_param_check
    $error("flop_pipe_dp: WIDTH=%0d / DEPTH=%0d outside legal range", WIDTH, DEPTH);
  end

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH:0]   accept;
  logic             scan_active;

`ifdef FLOP_PIPE_SCAN_EN
  assign scan_active = scan_en;
  assign scan_out    = stage_data[DEPTH-1][WIDTH-1];
`else
  assign scan_active = 1'b0;
`endif

  // accept ripples from the output back toward the input through the valid chain.
  always_comb begin
    accept        = '0;
    accept[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      accept[i] = !stage_valid[i] | accept[i+1];
    end
  end

  assign in_ready  = accept[0] & ~reset & ~flush & ~scan_active;
  assign out_valid = stage_valid[DEPTH-1] & ~scan_active;
  assign out_data  = stage_data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
`ifdef FLOP_PIPE_SCAN_EN
    logic             chain_in;
`endif

    if (i == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = in_data;
`ifdef FLOP_PIPE_SCAN_EN
      assign chain_in = scan_in;
`endif
    end else begin : g_next
      assign up_valid = stage_valid[i-1];
      assign up_data  = stage_data[i-1];
`ifdef FLOP_PIPE_SCAN_EN
      assign chain_in = stage_data[i-1][WIDTH-1];
`endif
    end

    flop_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .load     (accept[i]),
      .clear    (flush),
      .up_valid (up_valid),
      .up_data  (up_data),
`ifdef FLOP_PIPE_SCAN_EN
      .scan_en  (scan_en),
      .scan_in  (chain_in),
`endif
      .valid_q  (stage_valid[i]),
      .data_q   (stage_data[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_flop_pipe_dp.sv
// ============================================================================
// Module : tb_flop_pipe_dp
// Brief  : Self-checking bench for flop_pipe_dp: directed scenarios plus a
//          randomized run against a queue-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flop_pipe_dp;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

`ifdef FLOP_PIPE_SCAN_EN
  logic m_scan_en, m_scan_in, m_scan_out;
  logic s_scan_en, s_scan_in, s_scan_out;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0] s_in_data, s_out_data;
  logic s_flush;
`endif

  flop_pipe_dp #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef FLOP_PIPE_SCAN_EN
    .scan_en   (m_scan_en),
    .scan_in   (m_scan_in),
    .scan_out  (m_scan_out),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef FLOP_PIPE_SCAN_EN
  flop_pipe_dp #(.WIDTH(4), .DEPTH(2)) u_scan_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (s_flush),
    .scan_en   (s_scan_en),
    .scan_in   (s_scan_in),
    .scan_out  (s_scan_out),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data)
  );
`endif

  // Reference model: ordered words (oldest first) with their stage position.
  logic [W-1:0] mq_data[$];
  int           mq_pos[$];
  logic [W-1:0] m_out_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_out_valid();
    return (mq_pos.size() != 0) && (mq_pos[0] == D - 1);
  endfunction

  // Any empty slot, or a draining output, lets a new word in.
  function automatic bit m_in_ready();
    return !reset && !flush && (out_ready || (mq_pos.size() < D));
  endfunction

  task automatic model_step();
    bit take;
    int n;
    bit mv [D];
    take = in_valid && m_in_ready();
    if (reset) begin
      mq_data.delete();
      mq_pos.delete();
      m_out_data = '0;
    end else if (flush) begin
      mq_data.delete();
      mq_pos.delete();
    end else begin
      n = mq_pos.size();
      for (int k = 0; k < n; k++) begin
        if (k == 0) mv[k] = (mq_pos[0] == D - 1) ? out_ready : 1'b1;
        else        mv[k] = (mq_pos[k-1] == mq_pos[k] + 1) ? mv[k-1] : 1'b1;
      end
      for (int k = 0; k < n; k++) begin
        if (mv[k]) begin
          mq_pos[k] = mq_pos[k] + 1;
          if (mq_pos[k] == D - 1) m_out_data = mq_data[k];
        end
      end
      if (n > 0 && mq_pos[0] == D) begin
        void'(mq_data.pop_front());
        void'(mq_pos.pop_front());
      end
      if (take) begin
        mq_data.push_back(in_data);
        mq_pos.push_back(0);
        if (D == 1) m_out_data = in_data;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // DUT will sample at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_out_valid", out_valid, m_out_valid());
        check("cyc_out_data",  out_data,  m_out_data);
        check("cyc_in_ready",  in_ready,  m_in_ready());
      end
      model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_bias;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef FLOP_PIPE_SCAN_EN
    m_scan_en = 1'b0; m_scan_in = 1'b0;
    s_scan_en = 1'b0; s_scan_in = 1'b0; s_flush = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
`endif
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_in_ready",  in_ready,  0);

    // Streaming
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11; #1;
    check("stream_in_ready", in_ready, 1);
    cyc();  check("stream_c1_valid", out_valid, 0);
    in_data = 8'h22; cyc();
    check("stream_c2_valid", out_valid, 1); check("stream_c2_data", out_data, 8'h11);
    check("model_pin_c2", m_out_data, 8'h11);
    in_data = 8'h33; cyc();
    check("stream_c3_data", out_data, 8'h22);
    in_valid = 1'b0; cyc();
    check("stream_c4_valid", out_valid, 1); check("stream_c4_data", out_data, 8'h33);
    cyc();
    check("empty_valid", out_valid, 0); check("empty_hold_data", out_data, 8'h33);

    // Backpressure
    in_valid = 1'b1; in_data = 8'hA1; cyc();
    in_data = 8'hA2; cyc();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    check("bp_full_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_data", out_data, 8'hA1);
      check("bp_stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; cyc();
    check("bp_rel_valid", out_valid, 1); check("bp_rel_data", out_data, 8'hA2);
    cyc();
    check("bp_drained", out_valid, 0);

    // Bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; in_data = 8'h66; #1;
    check("bubble_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    check("bubble_valid", out_valid, 1); check("bubble_data", out_data, 8'h55);
    check("bubble_full", in_ready, 0);
    check("model_pin_bubble", mq_pos.size(), 2);
    out_ready = 1'b1; cyc();
    check("bubble_second", out_data, 8'h66);
    cyc();

    // Flush with a simultaneous in_valid
    in_valid = 1'b1; in_data = 8'h44; cyc();
    flush = 1'b1; in_data = 8'h77; #1;
    check("flush_in_ready", in_ready, 0);
    cyc(); flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_valid", out_valid, 0); check("flush_hold_data", out_data, 8'h66);
    for (int i = 0; i < 3; i++) begin
      cyc(); check("flush_no_emerge", out_valid, 0);
    end

    // Reset mid-stream
    in_valid = 1'b1; in_data = 8'h81; cyc();
    in_data = 8'h82; cyc();
    in_valid = 1'b0; #1;
    check("rst_mid_pre", out_data, 8'h81);
    reset = 1'b1; #1;
    check("rst_mid_in_ready", in_ready, 0);
    cyc(); reset = 1'b0; #1;
    check("rst_mid_valid", out_valid, 0); check("rst_mid_data", out_data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(); check("rst_mid_no_emerge", out_valid, 0);
    end

    // Randomized traffic checked by the compare process
    ready_bias = 2;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) ready_bias = $urandom_range(0, 4);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) < ready_bias);
      in_data   = W'($urandom);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

`ifdef FLOP_PIPE_SCAN_EN
    begin
      logic [7:0] prior;
      logic [7:0] pat;
      prior = 8'b0101_1100;
      pat   = 8'b1011_0010;
      s_in_valid = 1'b1; s_in_data = 4'h5; cyc();
      s_in_data = 4'hC; cyc();
      s_in_valid = 1'b0; #1;
      check("scan_pre_data", s_out_data, 4'h5);
      s_scan_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
        s_scan_in = pat[7-k]; #1;
        check("scan_out_bit", s_scan_out, prior[7-k]);
        check("scan_out_valid", s_out_valid, 0);
        check("scan_in_ready", s_in_ready, 0);
        cyc();
      end
      s_scan_en = 1'b0; #1;
      check("scan_post_valid", s_out_valid, 1);
      check("scan_post_data", s_out_data, 4'hB);
      s_out_ready = 1'b1; cyc();
      check("scan_post_s0_valid", s_out_valid, 1);
      check("scan_post_s0_data", s_out_data, 4'h2);
      cyc();
      check("scan_post_empty", s_out_valid, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flop_pipe_dp.md
FLOP_PIPE_DP -- requirements
Module: flop_pipe_dp

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16. DEPTH=0 SHALL be rejected at elaboration.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port flush, input, 1, synchronous clear of all stage valid bits.
REQ-006 Port in_valid, input, 1, upstream data valid.
REQ-007 Port in_ready, output, 1, the block accepts in_data this cycle.
REQ-008 Port in_data, input, WIDTH, upstream data.
REQ-009 Port out_valid, output, 1, the last stage holds valid data.
REQ-010 Port out_ready, input, 1, downstream accepts out_data.
REQ-011 Port out_data, output, WIDTH, last-stage data register, driven directly from a flop.

Function
REQ-012 Each stage SHALL hold a data register and a valid bit; stage 0 is nearest the input.
REQ-013 Stage i SHALL load when accept_i is high; accept_i = !valid_i | accept_(i+1); for the last stage, accept = !valid_last | out_ready.
REQ-014 in_ready SHALL equal accept_0 (combinational from out_ready through the valid chain); a transfer occurs when in_valid & in_ready.
REQ-015 With out_ready held high, latency in_data -> out_data SHALL be exactly DEPTH cycles, and throughput SHALL be one word per cycle.
REQ-016 When a stage loads, its valid bit SHALL take the upstream valid (in_valid for stage 0); a stage that is not loading SHALL hold data and valid unchanged.
REQ-017 Full pipeline (all valid) with out_ready low: in_ready SHALL be 0 and no data SHALL be lost or duplicated.
REQ-018 Empty pipeline: out_valid SHALL be 0, and out_data SHALL hold its last value.
REQ-019 flush high: all valid bits SHALL clear at the next edge, data registers SHALL be unchanged, and in_ready SHALL be forced to 0 that cycle, so flush beats a simultaneous in_valid.
REQ-020 Bubbles SHALL collapse: an invalid stage always accepts, even when downstream is stalled.

Reset
REQ-021 With reset high at an edge, all valid bits and all data registers SHALL be 0; after that edge, out_valid=0 and out_data=0.
REQ-022 Reset SHALL take priority over flush, handshake and scan; reset mid-transfer SHALL discard all in-flight words.
REQ-023 in_ready SHALL be 0 while reset is high.

Configuration
REQ-024 Macro FLOP_PIPE_SCAN_EN, when defined, SHALL add these ports: scan_en (input, 1), scan_in (input, 1) and scan_out (output, 1).
REQ-025 With FLOP_PIPE_SCAN_EN defined and scan_en high:
- All data bits SHALL form one shift chain, advancing 1 bit per cycle, ordered scan_in -> stage0 bit0..bit WIDTH-1 -> stage1 bit0 .. -> last stage bit WIDTH-1 -> scan_out.
- Valid bits SHALL be frozen.
- in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-026 With FLOP_PIPE_SCAN_EN defined, scan_out SHALL be the last-stage bit WIDTH-1 flop output.
REQ-027 Without FLOP_PIPE_SCAN_EN, the scan ports and scan logic SHALL be absent, and behaviour SHALL match REQ-012..023 exactly.

Structure
REQ-028 Package flop_pipe_pkg SHALL hold FLOP_PIPE_WIDTH_DEF=8, FLOP_PIPE_DEPTH_DEF=2 and the legal-range limit constants.
REQ-029 One sub-module, flop_pipe_stage, SHALL contain one stage: WIDTH data register, valid bit, load mux, and the optional scan mux; flop_pipe_dp SHALL instantiate it DEPTH times in a generate loop.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Streaming: reset, then WIDTH=8, DEPTH=2, out_ready=1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_valid high with out_data 0x11,0x22,0x33 on cycles 2,3,4 after the first transfer.
- Backpressure: fill the pipe with 0xA1,0xA2, then drop out_ready for 5 cycles -> in_ready=0 and out_data stable 0xA1. Raise out_ready -> 0xA1 then 0xA2 each appear exactly once.
- Bubble collapse: stage1 valid (0x55), stage0 empty, out_ready=0, in_valid with 0x66 -> accepted; next cycle both stages valid.
- Flush with simultaneous in_valid (0x77) -> next cycle out_valid=0, 0x77 never emerges, and out_data retains its prior value.
- Reset mid-stream with 2 words in flight -> next cycle out_valid=0 and out_data=0x00, and neither word emerges afterwards.
- With FLOP_PIPE_SCAN_EN, WIDTH=4, DEPTH=2: shift 8 bits 1,0,1,1,0,0,1,0 via scan_in -> scan_out shows the prior chain contents MSB-of-last-stage first, and valid bits are unchanged afterwards.
